avalon_mm_slave_mem: RTL and testbench
======================================

// Module: avalon_mm_slave_mem
// PURPOSE
//  Synthesizable Avalon-MM responder: word-addressed on-chip memory with byte-enable writes,
//  programmable wait states, response codes and read-only transfer counters in a CSR window.
//  Serves as the slave end for the master-side Avalon-MM bus tasks, and as a scratch/descriptor
//  memory behind rd_ctrl.
// PARAMETERS
//  ADDR_WIDTH   32      byte-address width
//  DATA_WIDTH   32      data width; multiple of 8; byteenable = DATA_WIDTH/8
//  DEPTH        256     memory words; power of two
//  WAIT_STATES  0       extra waitrequest-high cycles per transfer, 0..15
//  CSR_BASE     'h1000  byte address of counter window (3 words)
// PORTS
//  clock        in   1             rising-edge clock
//  reset        in   1             asynchronous, active-low reset
//  address      in   ADDR_WIDTH    byte address
//  byteenable   in   DATA_WIDTH/8  write byte lanes
//  read         in   1             read request
//  write        in   1             write request
//  writedata    in   DATA_WIDTH    write data
//  readdata     out  DATA_WIDTH    read data, valid when waitrequest==0
//  response     out  2             00 OKAY, 10 SLVERR, 11 DECODEERROR
//  waitrequest  out  1             1 = stall; 0 for exactly one cycle per completed transfer
// BEHAVIOUR
//  Reset: FSM=IDLE, waitrequest=1, readdata=0, response=00, counters=0; memory contents retained.
//  Reset mid-transfer aborts it: no write commit, no counter update.
//  FSM: IDLE -> (read|write sampled) -> WAIT (if WAIT_STATES>0) or ACK; WAIT counts down
//   WAIT_STATES cycles -> ACK; ACK drives waitrequest=0 one cycle -> IDLE.
//  Latency: command sampled at edge N gives waitrequest==0 in cycle N+1+WAIT_STATES.
//  address/byteenable/writedata are latched at the IDLE sample; later master changes are ignored
//   until ACK.
//  read|write high in the cycle after ACK is a new transfer; no combinational path from inputs
//   to outputs.
//  Decode, in priority order:
//   - read&write both high -> SLVERR, no write, readdata=0
//   - address[1:0]!=0 -> SLVERR
//   - word index in [0,DEPTH) -> memory
//   - CSR_BASE+{0,4,8} -> counters (read-only; writes -> SLVERR, no effect)
//   - anything else -> DECODEERROR, readdata=0
//  Memory write: commits at the ACK edge; only lanes with byteenable[i]=1 change.
//   byteenable==0 -> OKAY, no change.
//  Memory read: full word regardless of byteenable; readdata registered, valid only in the ACK
//   cycle, held to the next ACK.
//  Counters (32 b, wrap 2^32-1 -> 0, updated at ACK edge):
//   - rd_cnt: OKAY reads; CSR reads also count, post-read value shown on the next read
//   - wr_cnt: OKAY writes
//   - err_cnt: non-OKAY responses
//  response: valid only in the ACK cycle; 00 otherwise.
// STRUCTURE
//  avalon_mm_pkg:
//   - resp_t enum (OKAY=2'b00, SLVERR=2'b10, DECODEERROR=2'b11)
//   - slv_state_t enum {IDLE, WAIT, ACK}
//   - CSR offset constants
//  Sub-module avalon_mm_be_ram: DEPTH x DATA_WIDTH single-port RAM, per-byte write enable,
//   registered read.
//  Top holds FSM, wait counter, decode, counters, output registers.
// TESTING (bench drives the master-side Avalon-MM write/read tasks; run WAIT_STATES=0 and 3)
//  - Reset: hold reset=0 5 cycles -> waitrequest=1, response=00, readdata=0; release -> IDLE.
//  - Write 'hDEADBEEF to 'h10 (be='hF), then read 'h10 -> 'hDEADBEEF, OKAY;
//    waitrequest low exactly at N+1+WAIT_STATES.
//  - Write 'h11223344 to 'h10 with be='b0101, then read -> 'hDE22BE44, OKAY.
//  - Read 'h2 -> SLVERR; read DEPTH*4 -> DECODEERROR, readdata=0;
//    write to CSR_BASE -> SLVERR; err_cnt (CSR_BASE+8) reads 3.
//  - Back-to-back 8 writes then 8 reads with read held high across ACK -> 16 single-cycle ACKs;
//    wr_cnt=8, rd_cnt=8.
//  - Assert reset during a write's WAIT phase (WAIT_STATES=3) -> target word unchanged,
//    counters 0, waitrequest=1.

Source files
------------

// File: rtl/avalon_mm_pkg.sv
// Shared types and constants for the Avalon-MM slave memory.
package avalon_mm_pkg;

  typedef enum logic [1:0] {
    OKAY        = 2'b00,
    SLVERR      = 2'b10,
    DECODEERROR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } slv_state_t;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_MEM,
    TGT_CSR
  } tgt_t;

  typedef enum logic [1:0] {
    CSR_SEL_RD,
    CSR_SEL_WR,
    CSR_SEL_ERR
  } csr_sel_t;

  // Byte offsets of the counter words from CSR_BASE
  localparam int unsigned CSR_OFF_RD  = 0;
  localparam int unsigned CSR_OFF_WR  = 4;
  localparam int unsigned CSR_OFF_ERR = 8;

  localparam int unsigned CNT_W = 32;

  // Outcome of address decode for one transfer
  typedef struct packed {
    resp_t    resp;
    tgt_t     tgt;
    csr_sel_t csr_sel;
  } dec_t;

endpackage

// File: rtl/avalon_mm_slave_mem_if.sv
// Avalon-MM bus signals between a master and the slave memory.
interface avalon_mm_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [BE_W-1:0]       byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic [1:0]            response;
  logic                  waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, response, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, response, waitrequest
  );
endinterface

// File: rtl/avalon_mm_be_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module avalon_mm_be_ram #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic                       rd_en,
  input  logic                       we,
  input  logic [DATA_WIDTH/8-1:0]    be,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [DATA_WIDTH-1:0]      rdata_q
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane write; contents are not reset
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Registered read, holds its value until the next read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[addr];
  end
endmodule

// File: rtl/avalon_mm_slave_mem.sv
// Avalon-MM slave: byte-enable memory, wait states, response codes, counter CSRs.
module avalon_mm_slave_mem
  import avalon_mm_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 256,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] CSR_BASE    = 'h1000
) (
  input logic                  clock,
  input logic                  reset,
  avalon_mm_slave_mem_if.slave bus
);
  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(BE_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WCNT_W = 4;

  slv_state_t            state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  dec_t                  dec_q, dec_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rsel_q, rsel_d;
  resp_t                 response_q, response_d;
  logic                  waitrequest_q, waitrequest_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;

  dec_t                  dec_live, cur_dec;
  logic                  cur_rd, enter_ack;
  logic                  ram_rd_en, ram_we;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Priority decode of one request into response code and target
  function automatic dec_t decode(input logic rd, input logic wr,
                                  input logic [ADDR_WIDTH-1:0] a);
    dec_t d;
    d.resp    = OKAY;
    d.tgt     = TGT_NONE;
    d.csr_sel = CSR_SEL_RD;
    if (rd && wr) begin
      d.resp = SLVERR;
    end else if (a[OFF_W-1:0] != '0) begin
      d.resp = SLVERR;
    end else if ((a >> OFF_W) < ADDR_WIDTH'(DEPTH)) begin
      d.tgt = TGT_MEM;
    end else if (a == CSR_BASE + ADDR_WIDTH'(CSR_OFF_RD) ||
                 a == CSR_BASE + ADDR_WIDTH'(CSR_OFF_WR) ||
                 a == CSR_BASE + ADDR_WIDTH'(CSR_OFF_ERR)) begin
      d.tgt = TGT_CSR;
      if (a == CSR_BASE + ADDR_WIDTH'(CSR_OFF_WR))       d.csr_sel = CSR_SEL_WR;
      else if (a == CSR_BASE + ADDR_WIDTH'(CSR_OFF_ERR)) d.csr_sel = CSR_SEL_ERR;
      if (wr) d.resp = SLVERR;
    end else begin
      d.resp = DECODEERROR;
    end
    return d;
  endfunction

  // Next-state, command latch, ACK-cycle outputs and counter updates
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    idx_d         = idx_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    dec_d         = dec_q;
    rdata_d       = rdata_q;
    rsel_d        = rsel_q;
    response_d    = OKAY;
    waitrequest_d = 1'b1;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    err_cnt_d     = err_cnt_q;
    ram_rd_en     = 1'b0;
    ram_we        = 1'b0;
    enter_ack     = 1'b0;
    cur_dec       = dec_q;
    cur_rd        = rd_q;
    dec_live      = decode(bus.read, bus.write, bus.address);
    ram_addr      = (state_q == IDLE) ? bus.address[OFF_W +: IDX_W] : idx_q;

    case (state_q)
      IDLE: begin
        if (bus.read || bus.write) begin
          rd_d    = bus.read;
          wr_d    = bus.write;
          idx_d   = bus.address[OFF_W +: IDX_W];
          be_d    = bus.byteenable;
          wdata_d = bus.writedata;
          dec_d   = dec_live;
          if (WAIT_STATES == 0) begin
            state_d   = ACK;
            enter_ack = 1'b1;
            cur_dec   = dec_live;
            cur_rd    = bus.read;
          end else begin
            state_d = WAIT;
            wcnt_d  = WCNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
        if (dec_q.resp != OKAY) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end else if (wr_q) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          ram_we   = (dec_q.tgt == TGT_MEM);
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data is captured on the edge entering ACK so it is stable for the whole ACK cycle
    if (enter_ack) begin
      waitrequest_d = 1'b0;
      response_d    = cur_dec.resp;
      rsel_d        = 1'b0;
      rdata_d       = '0;
      if (cur_rd && cur_dec.resp == OKAY) begin
        if (cur_dec.tgt == TGT_MEM) begin
          ram_rd_en = 1'b1;
          rsel_d    = 1'b1;
        end else if (cur_dec.tgt == TGT_CSR) begin
          case (cur_dec.csr_sel)
            CSR_SEL_WR:  rdata_d = DATA_WIDTH'(wr_cnt_q);
            CSR_SEL_ERR: rdata_d = DATA_WIDTH'(err_cnt_q);
            default:     rdata_d = DATA_WIDTH'(rd_cnt_q);
          endcase
        end
      end
    end
  end

  // State and output registers; reset aborts any transfer in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      idx_q         <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      dec_q         <= '0;
      rdata_q       <= '0;
      rsel_q        <= 1'b0;
      response_q    <= OKAY;
      waitrequest_q <= 1'b1;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      idx_q         <= idx_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      dec_q         <= dec_d;
      rdata_q       <= rdata_d;
      rsel_q        <= rsel_d;
      response_q    <= response_d;
      waitrequest_q <= waitrequest_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  avalon_mm_be_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .addr    (ram_addr),
    .rd_en   (ram_rd_en),
    .we      (ram_we),
    .be      (be_q),
    .wdata   (wdata_q),
    .rdata_q (ram_rdata)
  );

  assign bus.waitrequest = waitrequest_q;
  assign bus.response    = response_q;
  assign bus.readdata    = rsel_q ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_avalon_mm_slave_mem.sv
// Bench for avalon_mm_slave_mem: two instances (0 and 3 wait states) exercised in turn.
module tb_avalon_mm_slave_mem;
  import avalon_mm_pkg::*;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned DEPTH    = 256;
  localparam logic [31:0] CSR_BASE = 32'h1000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        sel = 1'b0;
  logic [31:0] m_addr = '0;
  logic [3:0]  m_be = '0;
  logic        m_rd = 1'b0;
  logic        m_wr = 1'b0;
  logic [31:0] m_wdata = '0;

  avalon_mm_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  avalon_mm_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  assign bus0.address    = m_addr;
  assign bus0.byteenable = m_be;
  assign bus0.writedata  = m_wdata;
  assign bus0.read       = m_rd & ~sel;
  assign bus0.write      = m_wr & ~sel;
  assign bus3.address    = m_addr;
  assign bus3.byteenable = m_be;
  assign bus3.writedata  = m_wdata;
  assign bus3.read       = m_rd & sel;
  assign bus3.write      = m_wr & sel;

  logic [31:0] s_rdata;
  logic [1:0]  s_resp;
  logic        s_wait;
  assign s_rdata = sel ? bus3.readdata    : bus0.readdata;
  assign s_resp  = sel ? bus3.response    : bus0.response;
  assign s_wait  = sel ? bus3.waitrequest : bus0.waitrequest;

  avalon_mm_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0), .CSR_BASE(CSR_BASE)
  ) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  avalon_mm_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(3), .CSR_BASE(CSR_BASE)
  ) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [1:0]  resp;
    bit          chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;
  logic prev_wait = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ACK pops one expectation
  always @(negedge clock) begin
    if (mon_en && reset && !s_wait) begin
      check("ack_single", 32'(prev_wait), 32'd1);
      check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, "_resp"}, 32'(s_resp), 32'(e.resp));
        if (e.chk) check({e.tag, "_rdata"}, s_rdata, e.data);
      end
    end
    prev_wait = s_wait;
  end

  task automatic wait_ack();
    int n;
    int ws;
    n  = 0;
    ws = sel ? 3 : 0;
    do begin
      @(negedge clock);
      n++;
    end while (s_wait && n < 40);
    check("latency", 32'(n), 32'(ws + 1));
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d, input logic [1:0] er);
    exp_q.push_back('{tag, 32'h0, er, 1'b0});
    @(negedge clock);
    m_addr = a; m_be = be; m_wdata = d; m_wr = 1'b1; m_rd = 1'b0;
    wait_ack();
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] ed,
                         input logic [1:0] er, input bit chk);
    exp_q.push_back('{tag, ed, er, chk});
    @(negedge clock);
    m_addr = a; m_be = 4'h0; m_rd = 1'b1; m_wr = 1'b0;
    wait_ack();
  endtask

  task automatic do_rw(input string tag, input logic [31:0] a);
    exp_q.push_back('{tag, 32'h0, SLVERR, 1'b1});
    @(negedge clock);
    m_addr = a; m_be = 4'hF; m_wdata = 32'hA5A5A5A5; m_rd = 1'b1; m_wr = 1'b1;
    wait_ack();
  endtask

  task automatic go_idle();
    m_rd = 1'b0;
    m_wr = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clock);
    mon_en = 1'b0;
    reset  = 1'b0;
    go_idle();
    repeat (cycles) @(negedge clock);
    check("rst_wait", 32'(s_wait), 32'd1);
    check("rst_resp", 32'(s_resp), 32'd0);
    check("rst_rdata", s_rdata, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_wait", 32'(s_wait), 32'd1);
    mon_en = 1'b1;
  endtask

  task automatic basic_tests();
    do_write("w_deadbeef", 32'h10, 4'hF, 32'hDEADBEEF, OKAY);
    do_read ("r_deadbeef", 32'h10, 32'hDEADBEEF, OKAY, 1'b1);
    do_write("w_partial", 32'h10, 4'b0101, 32'h11223344, OKAY);
    do_read ("r_partial", 32'h10, 32'hDE22BE44, OKAY, 1'b1);
    do_read ("r_misalign", 32'h2, 32'h0, SLVERR, 1'b0);
    do_read ("r_decerr", 32'(DEPTH * 4), 32'h0, DECODEERROR, 1'b1);
    do_write("w_csr", CSR_BASE, 4'hF, 32'h12345678, SLVERR);
    do_read ("r_errcnt", CSR_BASE + 32'd8, 32'd3, OKAY, 1'b1);
    do_rw   ("rw_both", 32'h14);
    do_write("w_be0", 32'h10, 4'h0, 32'hFFFFFFFF, OKAY);
    do_read ("r_be0", 32'h10, 32'hDE22BE44, OKAY, 1'b1);
    do_read ("r_errcnt2", CSR_BASE + 32'd8, 32'd4, OKAY, 1'b1);
    do_read ("r_rdcnt", CSR_BASE, 32'd5, OKAY, 1'b1);
    do_read ("r_wrcnt", CSR_BASE + 32'd4, 32'd3, OKAY, 1'b1);
    go_idle();
  endtask

  task automatic b2b_tests();
    logic [31:0] model [8];
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      do_write($sformatf("b2b_w%0d", i), 32'h40 + 32'(i * 4), 4'hF, model[i], OKAY);
    end
    for (int i = 0; i < 8; i++) begin
      do_read($sformatf("b2b_r%0d", i), 32'h40 + 32'(i * 4), model[i], OKAY, 1'b1);
    end
    do_read("b2b_rdcnt", CSR_BASE, 32'd8, OKAY, 1'b1);
    do_read("b2b_wrcnt", CSR_BASE + 32'd4, 32'd8, OKAY, 1'b1);
    do_read("b2b_errcnt", CSR_BASE + 32'd8, 32'd0, OKAY, 1'b1);
    go_idle();
  endtask

  task automatic mid_reset_test();
    @(negedge clock);
    m_addr = 32'h10; m_be = 4'hF; m_wdata = 32'hCAFEF00D; m_wr = 1'b1; m_rd = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_in_wait", 32'(s_wait), 32'd1);
    mon_en = 1'b0;
    reset  = 1'b0;
    go_idle();
    @(negedge clock);
    check("mid_rst_wait", 32'(s_wait), 32'd1);
    @(negedge clock);
    reset  = 1'b1;
    mon_en = 1'b1;
    do_read("mid_rdcnt", CSR_BASE, 32'd0, OKAY, 1'b1);
    do_read("mid_wrcnt", CSR_BASE + 32'd4, 32'd0, OKAY, 1'b1);
    do_read("mid_errcnt", CSR_BASE + 32'd8, 32'd0, OKAY, 1'b1);
    do_read("mid_word", 32'h10, 32'hDE22BE44, OKAY, 1'b1);
    go_idle();
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      sel = 1'(p);
      apply_reset(5);
      basic_tests();
      apply_reset(2);
      b2b_tests();
      if (sel) mid_reset_test();
      go_idle();
      repeat (3) @(negedge clock);
    end
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
